// File: rtl/btn_conditioner.sv
// btn_conditioner: push-button input conditioning for the calculator core.
// Each bit: 2-flop synchronizer, debounce counter, press-pulse FSM.
// Outputs: a debounced level and a one-cycle registered press pulse.
// Optional build macro: BTN_AUTOREPEAT_EN adds auto-repeat pulses for the
// bits selected by REPEAT_MASK. Without it, each press gives exactly one pulse.
// Bit map: 0 = btnc, 1 = btnac, 2 = btnl, 3 = btnr, 4 = btnd.

module btn_conditioner #(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 3,
  parameter int unsigned REPEAT_MASK     = 32'h0000_0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time sanity checks on the configuration.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("btn_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end
  if (NUM_BTN < 1 || NUM_BTN > 32) begin : g_bad_num
    $error("btn_conditioner: NUM_BTN must be in 1..32");
  end
  if (NUM_BTN < 32 && (REPEAT_MASK >> NUM_BTN) != 0) begin : g_bad_mask
    $error("btn_conditioner: REPEAT_MASK selects buttons that do not exist");
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;
`else
  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;
`endif

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mismatch;
    logic             w_accept;
    logic             w_rise;
    logic             w_fall;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_pulse_nxt;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR_EN = ((REPEAT_MASK >> gi) & 32'd1) != 32'd0;
    logic [RPT_W-1:0] r_rpt;
    logic [RPT_W-1:0] w_rpt_nxt;
`endif

    // Two-flop synchronizer; only r_sync2 is used downstream.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= btn_raw[gi];
        r_sync2 <= r_sync1;
      end
    end

    assign w_mismatch = r_sync2 ^ r_level;
    assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);
    assign w_rise     = w_accept && r_sync2;
    assign w_fall     = w_accept && !r_sync2;

    // Debounce: level follows sync2 after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (!w_mismatch) begin
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end

    // Pulse FSM state register; the pulse is registered on the same edge as the level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        r_rpt   <= '0;
`endif
      end else begin
        r_state <= w_state_nxt;
        r_pulse <= w_pulse_nxt;
`ifdef BTN_AUTOREPEAT_EN
        r_rpt   <= w_rpt_nxt;
`endif
      end
    end

    // Pulse FSM next-state logic.
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        S_IDLE: begin
          if (w_rise) w_state_nxt = S_HELD;
        end
        S_HELD: begin
          if (w_fall) begin
            w_state_nxt = S_IDLE;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (AR_EN && r_rpt == DLY_LAST) begin
            w_state_nxt = S_REPEAT;
          end
`endif
        end
`ifdef BTN_AUTOREPEAT_EN
        S_REPEAT: begin
          if (w_fall) w_state_nxt = S_IDLE;
        end
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Pulse FSM outputs: next pulse value and repeat counter.
    always_comb begin
      w_pulse_nxt = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      w_rpt_nxt   = '0;
`endif
      case (r_state)
        S_IDLE: begin
          w_pulse_nxt = w_rise;
        end
        S_HELD: begin
`ifdef BTN_AUTOREPEAT_EN
          // A release on this edge wins over a due repeat, so no pulse with level low.
          if (AR_EN && !w_fall) begin
            if (r_rpt == DLY_LAST) begin
              w_pulse_nxt = 1'b1;
            end else begin
              w_rpt_nxt = r_rpt + RPT_W'(1);
            end
          end
`endif
        end
`ifdef BTN_AUTOREPEAT_EN
        S_REPEAT: begin
          if (!w_fall) begin
            if (r_rpt == PER_LAST) begin
              w_pulse_nxt = 1'b1;
            end else begin
              w_rpt_nxt = r_rpt + RPT_W'(1);
            end
          end
        end
`endif
        default: w_pulse_nxt = 1'b0;
      endcase
    end

    assign btn_level[gi] = r_level;
    assign btn_pulse[gi] = r_pulse;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with randomized and directed stimulus.
// Honors BTN_AUTOREPEAT_EN to select the expected pulse behaviour.

module tb_btn_conditioner;
  localparam int NB = 5;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;

  int checks = 0;
  int passes = 0;

  // Reference model state: captured raw history and expected outputs.
  logic [NB-1:0] hist [0:D];
  logic [NB-1:0] m_level;
  logic [NB-1:0] m_pulse;
  logic [NB-1:0] rmask;
  int            m_edge;
  int            m_t0 [NB];

  btn_conditioner #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK(32'h1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the model at the rising edge, return at the falling edge.
  // Level flips once the last D synchronized samples (raw delayed 2 edges) all differ from it.
  task automatic tick();
    bit flip;
    int off;
    @(posedge clk);
    if (rst) begin
      for (int j = 0; j <= D; j++) hist[j] = '0;
      m_level = '0;
      m_pulse = '0;
      m_edge  = 0;
    end else begin
      m_edge++;
      for (int b = 0; b < NB; b++) begin
        flip = 1'b1;
        for (int j = 1; j <= D; j++) if (hist[j][b] == m_level[b]) flip = 1'b0;
        m_pulse[b] = 1'b0;
        if (flip) begin
          m_level[b] = ~m_level[b];
          if (m_level[b]) begin
            m_pulse[b] = 1'b1;
            m_t0[b]    = m_edge;
          end
        end else if (m_level[b] && AR && rmask[b]) begin
          off = m_edge - m_t0[b];
          if (off >= RD && (off - RD) % RP == 0) m_pulse[b] = 1'b1;
        end
      end
      for (int j = D; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = btn_raw;
    end
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    btn_raw = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse)
        $display("FAIL settle: level=%b pulse=%b expected level=%b pulse=%b", btn_level, btn_pulse, m_level, m_pulse);
      else passes++;
    end
  endtask

  task automatic test_reset();
    logic [NB-1:0] el, ep;
    rst = 1'b1;
    btn_raw = '1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (btn_level !== '0 || btn_pulse !== '0)
        $display("FAIL reset_hold: level=%b pulse=%b expected 0/0", btn_level, btn_pulse);
      else passes++;
    end
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      el = (i >= 6) ? '1 : '0;
      ep = (i == 6) ? '1 : '0;
      checks++;
      if (btn_level !== el || btn_pulse !== ep)
        $display("FAIL reset_release edge %0d: level=%b pulse=%b expected %b/%b", i, btn_level, btn_pulse, el, ep);
      else passes++;
      checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse)
        $display("FAIL reset_model: level=%b pulse=%b model %b/%b", btn_level, btn_pulse, m_level, m_pulse);
      else passes++;
    end
    settle(12);
  endtask

  task automatic test_glitch();
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      btn_raw = (i < 3) ? 5'b00001 : 5'b00000;
      tick();
      if (btn_level[0] !== 1'b0 || btn_pulse[0] !== 1'b0) bad++;
      checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse)
        $display("FAIL glitch_model: level=%b pulse=%b model %b/%b", btn_level, btn_pulse, m_level, m_pulse);
      else passes++;
    end
    checks++;
    if (bad !== 0) $display("FAIL glitch_reject: %0d cycles with bit0 active, expected 0", bad);
    else passes++;
    settle(8);
  endtask

  task automatic test_bounce();
    bit seq [$];
    int pulses = 0, mp = 0, falls = 0, exp_p;
    logic prev = 1'b0;
    seq = '{1, 0, 1, 0};
    for (int i = 0; i < 20; i++) seq.push_back(1'b1);
    seq.push_back(1'b0); seq.push_back(1'b1);
    for (int i = 0; i < 20; i++) seq.push_back(1'b0);
    foreach (seq[i]) begin
      btn_raw = {4'b0000, seq[i]};
      tick();
      if (btn_pulse[0] === 1'b1) pulses++;
      if (m_pulse[0]) mp++;
      if (prev === 1'b1 && btn_level[0] === 1'b0) falls++;
      prev = btn_level[0];
      checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse)
        $display("FAIL bounce_model: level=%b pulse=%b model %b/%b", btn_level, btn_pulse, m_level, m_pulse);
      else passes++;
    end
    exp_p = AR ? mp : 1;
    checks++;
    if (pulses !== exp_p) $display("FAIL bounce_pulses: got %0d expected %0d", pulses, exp_p);
    else passes++;
    checks++;
    if (falls !== 1) $display("FAIL bounce_falls: got %0d expected 1", falls);
    else passes++;
    settle(6);
  endtask

  task automatic test_independent();
    int p0 = 0, p2 = 0, drop = 0;
    for (int i = 1; i <= 52; i++) begin
      btn_raw = '0;
      if (i <= 40) btn_raw[2] = 1'b1;
      if (i > 8 && i <= 18) btn_raw[0] = 1'b1;
      tick();
      if (btn_pulse[0] === 1'b1) p0++;
      if (btn_pulse[2] === 1'b1) p2++;
      if (i >= 6 && i <= 40 && btn_level[2] !== 1'b1) drop++;
      checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse)
        $display("FAIL indep_model: level=%b pulse=%b model %b/%b", btn_level, btn_pulse, m_level, m_pulse);
      else passes++;
    end
    checks++;
    if (drop !== 0) $display("FAIL indep_level2: btnl dropped %0d cycles, expected 0", drop);
    else passes++;
    checks++;
    if (p2 !== 1) $display("FAIL indep_pulse2: got %0d expected 1", p2);
    else passes++;
    checks++;
    if (p0 !== (AR ? 2 : 1)) $display("FAIL indep_pulse0: got %0d expected %0d", p0, AR ? 2 : 1);
    else passes++;
    settle(6);
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] el, ep;
    btn_raw = 5'b00010;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (btn_level !== '0 || btn_pulse !== '0)
      $display("FAIL resetmid_hold: level=%b pulse=%b expected 0/0", btn_level, btn_pulse);
    else passes++;
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      el = (i >= 6) ? 5'b00010 : 5'b00000;
      ep = (i == 6) ? 5'b00010 : 5'b00000;
      checks++;
      if (btn_level !== el || btn_pulse !== ep)
        $display("FAIL resetmid_release edge %0d: level=%b pulse=%b expected %b/%b", i, btn_level, btn_pulse, el, ep);
      else passes++;
    end
    settle(8);
  endtask

  task automatic test_autorepeat();
    logic el0, ep0, ep2;
    for (int i = 1; i <= 44; i++) begin
      btn_raw = (i <= 30) ? 5'b00101 : 5'b00000;
      tick();
      el0 = (i >= 6 && i <= 35);
      ep0 = el0 && (i == 6 || (AR && i >= 14 && (i - 14) % 3 == 0));
      ep2 = (i == 6);
      checks++;
      if (btn_level[0] !== el0 || btn_pulse[0] !== ep0 || btn_pulse[2] !== ep2)
        $display("FAIL autorepeat edge %0d: level0=%b pulse0=%b pulse2=%b expected %b/%b/%b",
                 i, btn_level[0], btn_pulse[0], btn_pulse[2], el0, ep0, ep2);
      else passes++;
      checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse)
        $display("FAIL autorepeat_model: level=%b pulse=%b model %b/%b", btn_level, btn_pulse, m_level, m_pulse);
      else passes++;
    end
    settle(6);
  endtask

  task automatic test_random();
    int hold [NB];
    for (int b = 0; b < NB; b++) hold[b] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < NB; b++) begin
        if (hold[b] == 0) begin
          btn_raw[b] = 1'($urandom_range(0, 1));
          hold[b]    = $urandom_range(1, 14);
        end
        hold[b]--;
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse)
        $display("FAIL random cycle %0d: level=%b pulse=%b model %b/%b", i, btn_level, btn_pulse, m_level, m_pulse);
      else passes++;
      checks++;
      if ((btn_pulse & ~btn_level) !== '0)
        $display("FAIL random_pulse_low cycle %0d: pulse=%b level=%b", i, btn_pulse, btn_level);
      else passes++;
    end
    rst = 1'b0;
    settle(10);
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = '0;
    rmask   = 5'b00001;
    for (int j = 0; j <= D; j++) hist[j] = '0;
    m_level = '0;
    m_pulse = '0;
    m_edge  = 0;
    for (int b = 0; b < NB; b++) m_t0[b] = 0;
    test_reset();
    test_glitch();
    test_bounce();
    test_independent();
    test_reset_mid();
    test_autorepeat();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-conditioning stage directly upstream of the calculator core.
- Takes the raw, asynchronous, bouncing board push-buttons and produces two outputs per button: a synchronized, debounced level, and a single-cycle press pulse.
- The calculator's accumulate (btnc) and clear (btnac) inputs are driven by pulses, so one press acts exactly once; its operation-select inputs (btnl, btnr, btnd) are driven by levels.

Parameters:
- NUM_BTN, 5: number of buttons. Bit map: 0 = btnc, 1 = btnac, 2 = btnl, 3 = btnr, 4 = btnd.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required to accept a level change. Use 4 in simulation, 1000000 on the board. Must be ≥ 2.
- REPEAT_DELAY, 8: cycles from the press pulse to the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 3: cycles between subsequent auto-repeat pulses. Used only with the optional feature.
- REPEAT_MASK, 5'b00001: buttons eligible for auto-repeat. Used only with the optional feature.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- btn_raw  input  NUM_BTN  raw button pins, asynchronous to clk
- btn_level  output  NUM_BTN  debounced level, registered
- btn_pulse  output  NUM_BTN  one-cycle press pulse, registered

Behaviour:
Reset:
- rst=1 immediately clears all state: synchronizer flops, counters, levels, FSMs, btn_level=0, btn_pulse=0.
- Reset asserted mid-count or mid-hold discards all progress.
- A button still held when rst deasserts is treated as a new press: it gets a full debounce, then one pulse.

Per-bit channel (all bits independent; simultaneous events on different bits never interact):
- Synchronizer: 2-flop chain sync1 -> sync2. Only sync2 is used downstream.
- Debounce counter: width ceil(log2(DEBOUNCE_CYCLES)).
  - Each edge with sync2 != btn_level: cnt increments.
  - Each edge with sync2 == btn_level: cnt clears to 0.
  - When sync2 != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= sync2 and cnt <= 0.
  - Net effect: level changes after exactly DEBOUNCE_CYCLES consecutive mismatching synchronized samples.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles is ignored.
- Latency: if raw changes and is first sampled at edge k, btn_level changes at edge k+1+DEBOUNCE_CYCLES. With the default of 4, that is 5 edges after first capture, i.e. visible after the 6th edge counted inclusively.

Pulse FSM per bit, states IDLE, HELD, REPEAT:
- IDLE: on the edge where btn_level goes 0->1, assert btn_pulse for exactly one cycle (same edge as the level update) and go to HELD.
- HELD: stay while btn_level=1. When btn_level goes 1->0, go to IDLE with no pulse. Release never pulses.
- REPEAT: reachable only with the optional feature.

Other rules:
- btn_pulse is high for at most one cycle per press and is never high while btn_level=0.
- Multiple bits may pulse in the same cycle. Priority between them (e.g. clear over accumulate) is the consumer's job, not this block's.
- No combinational path from btn_raw to any output.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined, for bits in REPEAT_MASK:
  - HELD keeps a repeat counter. If btn_level is still 1 REPEAT_DELAY cycles after the press pulse, emit one pulse and enter REPEAT.
  - REPEAT emits one pulse every REPEAT_PERIOD cycles while held.
  - Release in either state returns the FSM to IDLE and clears the repeat counter the same edge, with no pulse.
- Defined, for bits not in REPEAT_MASK: behaviour is identical to the macro being undefined.
- Undefined: REPEAT state and repeat counters are not synthesized. REPEAT_* parameters are accepted and ignored. Exactly one pulse per press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
1. Reset with held buttons: rst=1 with btn_raw=5'h1F -> btn_level=0 and btn_pulse=0 throughout. Deassert rst, hold raw -> btn_level=5'h1F and btn_pulse=5'h1F for exactly one cycle, 5 edges after the first post-reset capture; btn_pulse=0 afterwards.
2. Glitch rejection: btn_raw[0]=1 for 3 cycles, then 0 -> btn_level[0] and btn_pulse[0] stay 0 for the whole run.
3. Bounce on press and release: raw bit 0 = 1,0,1,0,then 1 held for 20 cycles, then 0,1,0 held -> exactly one btn_pulse[0] (4 stable synchronized cycles after the final rise), btn_level[0] falls once, no release pulse.
4. Independent channels: hold btn_raw[2] (btnl), then tap btn_raw[0] for 10 cycles -> btn_level[2]=1 steady, a single btn_pulse[0], btn_pulse[2] only at btnl's own press.
5. Reset mid-debounce: raise btn_raw[1], assert rst after 2 synchronized cycles, deassert one cycle later with raw still high -> outputs 0 during rst; btn_pulse[1] arrives a full 5 edges after the post-reset capture, not earlier.
6. Auto-repeat (BTN_AUTOREPEAT_EN): hold btn_raw[0] and btn_raw[2] 30 cycles, first pulse at cycle t0 -> btn_pulse[0] at t0, t0+8, t0+11, t0+14, … until release. btn_pulse[2] only at its press. Rerun with the macro undefined -> only the t0 pulse on bit 0.
